score_keeper: RTL
=================

# score_keeper

Game-state back end for the hit pipeline. Consumes the hit indication from the hit detector and the miss indication from the sprite mover (object left screen unhit), and maintains score, combo streak, multiplier, remaining lives and game-over. Replaces the ad-hoc `posedge hit` score counter with a single-clock, edge-detected, saturating tracker whose outputs feed the graphics block.

## Interface
- `SCORE_W`, 8: score width, in bits.
- `LIVES`, 3: lives at reset/restart, 1..3.
- `BONUS_STEP`, 4: consecutive hits per multiplier step.
- `MULT_MAX`, 4: multiplier ceiling, 1..7.
- `clk` input 1: system clock (CLOCK_50 at top).
- `reset` input 1: asynchronous, active-high; all state to reset values.
- `hit` input 1: level from hit detector; each rising edge is one hit.
- `miss` input 1: level from sprite mover; each rising edge is one miss.
- `restart` input 1: level; rising edge starts a new game.
- `score` output SCORE_W: accumulated score, saturating.
- `combo` output 4: consecutive hits since last miss, saturates at 15.
- `mult` output 3: current multiplier, 1..MULT_MAX.
- `lives` output 2: remaining lives.
- `game_over` output 1: high in OVER state.
- `score_evt` output 1: one-cycle pulse on every accepted hit.
- `hiscore` output SCORE_W: best score since reset (see Configuration).

## Operation
- Reset values: score=0, combo=0, mult=1, lives=LIVES, game_over=0, score_evt=0, hiscore=0, state=PLAY, edge registers=0.
- Edge detection: each of hit/miss/restart is registered once; the event is `in & ~in_q`. A held level yields exactly one event.
- States: PLAY and OVER.
- PLAY, hit event: score += mult (current value, before combo update), saturating at 2^SCORE_W-1. combo += 1, saturating at 15. mult = min(1 + combo_new / BONUS_STEP, MULT_MAX). score_evt=1 for that cycle.
- PLAY, miss event: combo=0, mult=1, lives -= 1. If lives was 1, go to OVER the same edge (lives=0, game_over=1).
- PLAY, hit and miss events in the same cycle: the hit is processed and the miss is discarded; the object was struck.
- OVER: hit and miss events are ignored. score_evt stays 0. score, combo and mult hold.
- Restart event, in either state, has priority over hit and miss in the same cycle. It sets score=0, combo=0, mult=1, lives=LIVES, state=PLAY. hiscore is kept.
- Reset asserted mid-game: all outputs return to reset values immediately (asynchronous). The edge registers clear, so an input already high at reset release produces an event on the first clock after release.

## Timing
- Input first sampled high at edge n: the corresponding output update is visible after edge n (single register stage, event decode combinational from in and in_q).
- score_evt is high for exactly one cycle, aligned with the score update.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Back-to-back events: a new edge is accepted once the input has been low for at least one sampled cycle. Minimum event spacing is 2 cycles.

## Configuration
- `SCORE_HISCORE_EN` defined: hiscore register updates to score whenever score > hiscore. The update is registered, 1 cycle behind score. hiscore survives restart and clears only on reset.
- Not defined: no register is built and hiscore is tied to 0.

## Structure
- Shared package `score_pkg`: state enum (PLAY, OVER), COMBO_W=4, MULT_W=3, LIVES_W=2 constants.
- Sub-module `rise_edge`: a single-bit register plus AND-NOT. Instantiate it three times (hit, miss, restart).
- Everything else lives in one always block with async reset, plus combinational next-state logic.

## Test plan
- Reset, then 5 hit pulses spaced 4 cycles apart (BONUS_STEP=4) -> score 1,2,3,4,6; combo 5; mult 2; five score_evt pulses.
- Hit held high for 20 cycles -> exactly one event: score=1, combo=1.
- 3 miss pulses -> lives 2,1,0; game_over=1 on the third. A following hit leaves score unchanged and score_evt stays 0.
- Hit and miss rising in the same cycle with lives=3, combo=2 -> score +1, combo=3, lives stays 3.
- Preload score near saturation via 100 hits -> score holds at 255. Then restart -> score 0, lives 3, PLAY. With SCORE_HISCORE_EN, hiscore stays 255.
- Assert reset asynchronously mid-stream with score=37 -> all outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and widths for the score_keeper game-state tracker.
package score_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  localparam int COMBO_W = 4;
  localparam int MULT_W  = 3;
  localparam int LIVES_W = 2;

  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

  // Multiplier for a given streak: one step per `step` consecutive hits, capped.
  function automatic logic [MULT_W-1:0] mult_for(input logic [COMBO_W-1:0] combo,
                                                 input int step,
                                                 input int max_mult);
    int m;
    m = 1 + int'(combo) / step;
    if (m > max_mult) m = max_mult;
    return MULT_W'(m);
  endfunction

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector: one register stage, event = level & ~level_q.
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic evt
);

  logic level_q;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign evt = level & ~level_q;

endmodule

// File: rtl/score_keeper.sv
// Score, combo, multiplier, lives and game-over tracker for the hit pipeline.
// Optional high-score register is built when SCORE_HISCORE_EN is defined.
module score_keeper
  import score_pkg::*;
#(
  parameter int SCORE_W    = 8,
  parameter int LIVES      = 3,
  parameter int BONUS_STEP = 4,
  parameter int MULT_MAX   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hit,
  input  logic               miss,
  input  logic               restart,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [MULT_W-1:0]  mult,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over,
  output logic               score_evt,
  output logic [SCORE_W-1:0] hiscore
);

  logic hit_evt, miss_evt, restart_evt;

  rise_edge u_hit_edge     (.clk(clk), .reset(reset), .level(hit),     .evt(hit_evt));
  rise_edge u_miss_edge    (.clk(clk), .reset(reset), .level(miss),    .evt(miss_evt));
  rise_edge u_restart_edge (.clk(clk), .reset(reset), .level(restart), .evt(restart_evt));

  state_t             state, state_n;
  logic [SCORE_W-1:0] score_n;
  logic [COMBO_W-1:0] combo_n;
  logic [MULT_W-1:0]  mult_n;
  logic [LIVES_W-1:0] lives_n;
  logic               score_evt_n;
  logic [SCORE_W:0]   sum;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n     = state;
    score_n     = score;
    combo_n     = combo;
    mult_n      = mult;
    lives_n     = lives;
    score_evt_n = 1'b0;
    sum         = {1'b0, score} + (SCORE_W+1)'(mult);

    if (restart_evt) begin
      state_n = PLAY;
      score_n = '0;
      combo_n = '0;
      mult_n  = MULT_W'(1);
      lives_n = LIVES_W'(LIVES);
    end else if (state == PLAY) begin
      // A simultaneous miss is dropped: the object was struck.
      if (hit_evt) begin
        score_n     = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        combo_n     = (combo == COMBO_MAX) ? combo : combo + 1'b1;
        mult_n      = mult_for(combo_n, BONUS_STEP, MULT_MAX);
        score_evt_n = 1'b1;
      end else if (miss_evt) begin
        combo_n = '0;
        mult_n  = MULT_W'(1);
        lives_n = lives - 1'b1;
        if (lives == LIVES_W'(1)) state_n = OVER;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PLAY;
      score     <= '0;
      combo     <= '0;
      mult      <= MULT_W'(1);
      lives     <= LIVES_W'(LIVES);
      score_evt <= 1'b0;
    end else begin
      state     <= state_n;
      score     <= score_n;
      combo     <= combo_n;
      mult      <= mult_n;
      lives     <= lives_n;
      score_evt <= score_evt_n;
    end
  end

  assign game_over = (state == OVER);

`ifdef SCORE_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q;

  // Trails score by one cycle; survives restart, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  hiscore_q <= '0;
    else if (score > hiscore_q) hiscore_q <= score;
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = '0;
`endif

endmodule
